ccip_mem_responder: RTL
=======================

CCIP_MEM_RESPONDER -- requirements
Module: ccip_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: line-address bits kept; memory depth 2^ADDR_W 512-bit lines.
REQ-002 SHALL have parameter Q_DEPTH, default 8: entries in each request queue (read and write).
REQ-003 SHALL have parameter ALMFULL_TH, default 5: occupancy at which almost-full asserts.
REQ-004 SHALL have one clock and an asynchronous, active-high reset.
REQ-005 pClk  in  1  sole clock; all logic on rising edge.
REQ-006 pck_cp2af_softReset  in  1  asynchronous, active-high reset.
REQ-007 c0_req_valid  in  1  read request from AFU.
REQ-008 c0_req_addr  in  42  read line address; low ADDR_W bits used.
REQ-009 c0_req_mdata  in  16  read tag.
REQ-010 c1_req_valid  in  1  write request from AFU.
REQ-011 c1_req_addr  in  42  write line address; low ADDR_W bits used.
REQ-012 c1_req_mdata  in  16  write tag.
REQ-013 c1_req_data  in  512  write line data.
REQ-014 c0_almfull  out  1  read queue almost full.
REQ-015 c1_almfull  out  1  write queue almost full.
REQ-016 c0_rsp_valid  out  1  read response.
REQ-017 c0_rsp_mdata  out  16  tag of completed read.
REQ-018 c0_rsp_data  out  512  read line data.
REQ-019 c1_rsp_valid  out  1  write completion.
REQ-020 c1_rsp_mdata  out  16  tag of completed write.
REQ-021 ovf_err  out  1  sticky: request arrived while its queue was full.

Function
REQ-022 Each valid request SHALL push {addr[ADDR_W-1:0], mdata[, data]} into its FIFO queue in the cycle it is presented.
REQ-023 A request arriving while its queue holds Q_DEPTH entries SHALL be dropped, SHALL not disturb queue contents, and SHALL set ovf_err until reset.
REQ-024 cX_almfull SHALL be registered and equal (occupancy >= ALMFULL_TH), occupancy taken after that cycle's push/pop.
REQ-025 A single-port memory SHALL service at most one queue head per cycle (write or read).
REQ-026 Arbiter: only one queue non-empty -> service it; both non-empty -> round-robin, last-serviced flag toggles; after reset first grant goes to write.
REQ-027 A head SHALL not be popped in its push cycle (minimum one cycle queue residency).
REQ-028 Write service cycle N: memory updated at edge ending N; c1_rsp_valid=1 with that mdata in cycle N+1.
REQ-029 Read service cycle N: c0_rsp_valid=1 with mdata and memory contents in cycle N+2.
REQ-030 Reads SHALL observe all writes serviced in earlier cycles; responses SHALL be in per-channel service order.
REQ-031 Responses have no backpressure; rsp_valid SHALL pulse exactly one cycle per serviced request.
REQ-032 Address bits above ADDR_W SHALL be ignored (aliasing wraps modulo 2^ADDR_W).
REQ-033 Pointers SHALL wrap modulo Q_DEPTH; simultaneous push and pop SHALL leave occupancy unchanged.

Reset
REQ-034 While reset asserted: queues empty, pipelines cleared, all outputs 0, arbiter flag = "read last"; memory contents undefined and not cleared.
REQ-035 Reset asserted mid-operation SHALL discard all in-flight requests; no response SHALL appear after deassertion for requests accepted before it.

Verification
REQ-036 Write addr 0x3, mdata 0x11, data 0xA5.. at cycle 0 -> c1_rsp_valid, mdata 0x11 at cycle 2; read addr 0x3 mdata 0x22 at cycle 4 -> c0_rsp data 0xA5.., mdata 0x22 at cycle 7.
REQ-037 Write and read both every cycle for 10 cycles -> services alternate W,R,..; both almfull assert when occupancy reaches 5; no ovf_err if AFU halts on almfull.
REQ-038 9 reads back-to-back with no writes while arbiter stalled by writes -> 9th dropped, ovf_err=1 and stays 1; first 8 tags return in order.
REQ-039 Write addr 0x1_0000_0005 data X, read addr 0x5 -> returns X (aliasing).
REQ-040 Assert reset with 4 reads queued -> outputs 0 within reset; after release no c0_rsp_valid for 10 cycles, almfull=0, ovf_err=0.

Source files
------------

// File: rtl/ccip_mem_responder.sv
// ccip_mem_responder
// CCI-P style memory responder model for AFU bring-up. Read and write
// requests are each buffered in their own FIFO queue. A single-port line
// memory serves at most one queue head per cycle, and a round-robin arbiter
// chooses between the two queues.
//
// Ports:
//   pClk                 - sole clock, rising edge
//   pck_cp2af_softReset  - asynchronous active-high reset
//   c0_req_*             - read request (valid, 42-bit line addr, 16-bit tag)
//   c1_req_*             - write request (valid, addr, tag, 512-bit data)
//   c0_almfull/c1_almfull- registered queue almost-full flags
//   c0_rsp_*             - read response (valid, tag, data), 2 cycles after service
//   c1_rsp_*             - write completion (valid, tag), 1 cycle after service
//   ovf_err              - sticky flag: a request was dropped on a full queue
module ccip_mem_responder #(
    parameter int ADDR_W     = 8,
    parameter int Q_DEPTH    = 8,
    parameter int ALMFULL_TH = 5
) (
    input  logic         pClk,
    input  logic         pck_cp2af_softReset,
    input  logic         c0_req_valid,
    input  logic [41:0]  c0_req_addr,
    input  logic [15:0]  c0_req_mdata,
    input  logic         c1_req_valid,
    input  logic [41:0]  c1_req_addr,
    input  logic [15:0]  c1_req_mdata,
    input  logic [511:0] c1_req_data,
    output logic         c0_almfull,
    output logic         c1_almfull,
    output logic         c0_rsp_valid,
    output logic [15:0]  c0_rsp_mdata,
    output logic [511:0] c0_rsp_data,
    output logic         c1_rsp_valid,
    output logic [15:0]  c1_rsp_mdata,
    output logic         ovf_err
);

    localparam int PTR_W = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
    localparam int CNT_W = $clog2(Q_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(Q_DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(Q_DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(ALMFULL_TH);

    // Queue storage and line memory (never reset; validity is tracked by counters)
    logic [ADDR_W-1:0] rdq_addr  [Q_DEPTH];
    logic [15:0]       rdq_mdata [Q_DEPTH];
    logic [ADDR_W-1:0] wrq_addr  [Q_DEPTH];
    logic [15:0]       wrq_mdata [Q_DEPTH];
    logic [511:0]      wrq_data  [Q_DEPTH];
    logic [511:0]      mem       [2**ADDR_W];
    logic [511:0]      rd_s1_data;

    logic [PTR_W-1:0] rd_wptr_q, rd_wptr_d, rd_rptr_q, rd_rptr_d;
    logic [PTR_W-1:0] wr_wptr_q, wr_wptr_d, wr_rptr_q, wr_rptr_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
    logic             last_wr_q, last_wr_d;
    logic             c0_almfull_q, c0_almfull_d, c1_almfull_q, c1_almfull_d;
    logic             ovf_q, ovf_d;
    logic             rd_s1_valid_q, rd_s1_valid_d;
    logic [15:0]      rd_s1_mdata_q, rd_s1_mdata_d;
    logic             c0_rsp_valid_q, c0_rsp_valid_d;
    logic [15:0]      c0_rsp_mdata_q, c0_rsp_mdata_d;
    logic [511:0]     c0_rsp_data_q, c0_rsp_data_d;
    logic             c1_rsp_valid_q, c1_rsp_valid_d;
    logic [15:0]      c1_rsp_mdata_q, c1_rsp_mdata_d;

    logic rd_full, wr_full, rd_push, wr_push, grant_rd, grant_wr;
    logic unused_addr_bits;

    assign unused_addr_bits = ^{c0_req_addr[41:ADDR_W], c1_req_addr[41:ADDR_W]};

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Arbitration uses the registered counts, so an entry pushed this cycle
    // is never visible to the arbiter until the next cycle.
    assign rd_full  = (rd_cnt_q == FULL_CNT);
    assign wr_full  = (wr_cnt_q == FULL_CNT);
    assign rd_push  = c0_req_valid && !rd_full;
    assign wr_push  = c1_req_valid && !wr_full;
    assign grant_wr = (wr_cnt_q != '0) && ((rd_cnt_q == '0) || !last_wr_q);
    assign grant_rd = (rd_cnt_q != '0) && !grant_wr;

    always_comb begin
        rd_wptr_d      = rd_wptr_q;
        rd_rptr_d      = rd_rptr_q;
        wr_wptr_d      = wr_wptr_q;
        wr_rptr_d      = wr_rptr_q;
        rd_cnt_d       = rd_cnt_q;
        wr_cnt_d       = wr_cnt_q;
        last_wr_d      = last_wr_q;
        ovf_d          = ovf_q | (c0_req_valid & rd_full) | (c1_req_valid & wr_full);

        if (rd_push)  rd_wptr_d = next_ptr(rd_wptr_q);
        if (grant_rd) rd_rptr_d = next_ptr(rd_rptr_q);
        if (wr_push)  wr_wptr_d = next_ptr(wr_wptr_q);
        if (grant_wr) wr_rptr_d = next_ptr(wr_rptr_q);

        case ({rd_push, grant_rd})
            2'b10:   rd_cnt_d = rd_cnt_q + 1'b1;
            2'b01:   rd_cnt_d = rd_cnt_q - 1'b1;
            default: rd_cnt_d = rd_cnt_q;
        endcase
        case ({wr_push, grant_wr})
            2'b10:   wr_cnt_d = wr_cnt_q + 1'b1;
            2'b01:   wr_cnt_d = wr_cnt_q - 1'b1;
            default: wr_cnt_d = wr_cnt_q;
        endcase

        c0_almfull_d = (rd_cnt_d >= AF_CNT);
        c1_almfull_d = (wr_cnt_d >= AF_CNT);

        // Flag records whichever queue was served most recently
        if (grant_wr)      last_wr_d = 1'b1;
        else if (grant_rd) last_wr_d = 1'b0;

        rd_s1_valid_d  = grant_rd;
        rd_s1_mdata_d  = grant_rd ? rdq_mdata[rd_rptr_q] : '0;
        c0_rsp_valid_d = rd_s1_valid_q;
        c0_rsp_mdata_d = rd_s1_mdata_q;
        c0_rsp_data_d  = rd_s1_valid_q ? rd_s1_data : '0;
        c1_rsp_valid_d = grant_wr;
        c1_rsp_mdata_d = grant_wr ? wrq_mdata[wr_rptr_q] : '0;
    end

    always_ff @(posedge pClk or posedge pck_cp2af_softReset) begin
        if (pck_cp2af_softReset) begin
            rd_wptr_q      <= '0;
            rd_rptr_q      <= '0;
            wr_wptr_q      <= '0;
            wr_rptr_q      <= '0;
            rd_cnt_q       <= '0;
            wr_cnt_q       <= '0;
            last_wr_q      <= 1'b0;
            c0_almfull_q   <= 1'b0;
            c1_almfull_q   <= 1'b0;
            ovf_q          <= 1'b0;
            rd_s1_valid_q  <= 1'b0;
            rd_s1_mdata_q  <= '0;
            c0_rsp_valid_q <= 1'b0;
            c0_rsp_mdata_q <= '0;
            c0_rsp_data_q  <= '0;
            c1_rsp_valid_q <= 1'b0;
            c1_rsp_mdata_q <= '0;
        end else begin
            rd_wptr_q      <= rd_wptr_d;
            rd_rptr_q      <= rd_rptr_d;
            wr_wptr_q      <= wr_wptr_d;
            wr_rptr_q      <= wr_rptr_d;
            rd_cnt_q       <= rd_cnt_d;
            wr_cnt_q       <= wr_cnt_d;
            last_wr_q      <= last_wr_d;
            c0_almfull_q   <= c0_almfull_d;
            c1_almfull_q   <= c1_almfull_d;
            ovf_q          <= ovf_d;
            rd_s1_valid_q  <= rd_s1_valid_d;
            rd_s1_mdata_q  <= rd_s1_mdata_d;
            c0_rsp_valid_q <= c0_rsp_valid_d;
            c0_rsp_mdata_q <= c0_rsp_mdata_d;
            c0_rsp_data_q  <= c0_rsp_data_d;
            c1_rsp_valid_q <= c1_rsp_valid_d;
            c1_rsp_mdata_q <= c1_rsp_mdata_d;
        end
    end

    // Queue payload storage; a dropped request never reaches these arrays.
    always_ff @(posedge pClk) begin
        if (rd_push) begin
            rdq_addr[rd_wptr_q]  <= c0_req_addr[ADDR_W-1:0];
            rdq_mdata[rd_wptr_q] <= c0_req_mdata;
        end
        if (wr_push) begin
            wrq_addr[wr_wptr_q]  <= c1_req_addr[ADDR_W-1:0];
            wrq_mdata[wr_wptr_q] <= c1_req_mdata;
            wrq_data[wr_wptr_q]  <= c1_req_data;
        end
    end

    // Single-port memory: one write or one read per cycle, never both.
    always_ff @(posedge pClk) begin
        if (grant_wr) begin
            mem[wrq_addr[wr_rptr_q]] <= wrq_data[wr_rptr_q];
        end else if (grant_rd) begin
            rd_s1_data <= mem[rdq_addr[rd_rptr_q]];
        end
    end

    assign c0_almfull   = c0_almfull_q;
    assign c1_almfull   = c1_almfull_q;
    assign c0_rsp_valid = c0_rsp_valid_q;
    assign c0_rsp_mdata = c0_rsp_mdata_q;
    assign c0_rsp_data  = c0_rsp_data_q;
    assign c1_rsp_valid = c1_rsp_valid_q;
    assign c1_rsp_mdata = c1_rsp_mdata_q;
    assign ovf_err      = ovf_q;

endmodule
